ysyx_20020207_ifu: RTL and testbench

YSYX_20020207_IFU -- requirements
Module: ysyx_20020207_ifu

---
 rtl/ysyx_20020207_pkg.sv | 19 +
 rtl/ysyx_20020207_pc_reg.sv | 36 +++
 rtl/ysyx_20020207_ifu.sv | 119 +++++++++++
 tb/tb_ysyx_20020207_ifu.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_20020207_pkg.sv
// Shared types and constants for the ysyx_20020207 instruction fetch unit.
package ysyx_20020207_pkg;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_EXEC,
    S_ERR
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ysyx_20020207_pc_reg.sv
// Fetch PC register with next-PC selection (sequential +4 or aligned redirect).
module ysyx_20020207_pc_reg
  import ysyx_20020207_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // The +4 path wraps naturally at 2^32.
  always_comb begin
    pc_d = pc_q;
    if (advance_i) begin
      pc_d = redirect_i ? align_word(redirect_pc_i) : pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_20020207_ifu.sv
// Instruction fetch unit: request/wait/hold/execute loop with a sticky fault state.
// Define IFU_PERF_CNT_EN to add the 64-bit perf_fetch_cnt accepted-response counter.
module ysyx_20020207_ifu
  import ysyx_20020207_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        commit,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0] perf_fetch_cnt
`endif
);

  ifu_state_e  state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] pc;
  logic        latch;
  logic        advance;

  ysyx_20020207_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .advance_i    (advance),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .pc_o         (pc)
  );

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    unique case (state_q)
      S_REQ:  if (imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            state_d = S_ERR;
          end else begin
            state_d = S_HOLD;
            latch   = 1'b1;
          end
        end
      end
      S_HOLD: if (inst_ready) state_d = S_EXEC;
      S_EXEC: if (commit) state_d = S_REQ;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    if (latch) begin
      inst_d    = imem_rsp_data;
      inst_pc_d = pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      inst_q    <= IFU_NOP;
      inst_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Only a commit seen while executing may move the PC.
  assign advance        = (state_q == S_EXEC) && commit;
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_addr      = pc;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_err      = (state_q == S_ERR);

`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_cnt_q, perf_cnt_d;

  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if ((state_q == S_WAIT) && imem_rsp_valid) perf_cnt_d = perf_cnt_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q <= 64'd0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_20020207_ifu.sv
// Self-checking bench for ysyx_20020207_ifu: directed scenarios then randomized traffic,
// compared every cycle against a transaction-level model of the fetch loop.
module tb_ysyx_20020207_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        commit = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_err;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
`endif

  always #5 clk = ~clk;

  ysyx_20020207_ifu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .commit        (commit),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .fetch_err     (fetch_err)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level view: where the current instruction is in its life.
  typedef enum {P_FETCH, P_WAIT, P_OFFER, P_EXEC, P_FAULT} phase_e;
  phase_e          m_ph;
  logic [31:0]     m_pc, m_inst, m_inst_pc;
  longint unsigned m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph      <= P_FETCH;
      m_pc      <= RST_PC;
      m_inst    <= NOP;
      m_inst_pc <= RST_PC;
      m_cnt     <= 0;
    end else begin
      case (m_ph)
        P_FETCH: if (imem_req_ready) m_ph <= P_WAIT;
        P_WAIT: begin
          if (imem_rsp_valid) begin
            m_cnt <= m_cnt + 1;
            if (imem_rsp_err) begin
              m_ph <= P_FAULT;
            end else begin
              m_inst    <= imem_rsp_data;
              m_inst_pc <= m_pc;
              m_ph      <= P_OFFER;
            end
          end
        end
        P_OFFER: if (inst_ready) m_ph <= P_EXEC;
        P_EXEC: begin
          if (commit) begin
            m_pc <= redirect ? redirect_pc - (redirect_pc % 4) : m_pc + 32'd4;
            m_ph <= P_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } lit_t;
  lit_t lits[$];

  task automatic expect_lit(input string name, input int sel, input logic [31:0] val);
    lit_t l;
    l.name = name;
    l.sel  = sel;
    l.val  = val;
    lits.push_back(l);
  endtask

  function automatic logic [31:0] dut_sig(input int sel);
    case (sel)
      0:       return {31'b0, imem_req_valid};
      1:       return imem_addr;
      2:       return {31'b0, inst_valid};
      3:       return inst;
      4:       return inst_pc;
      default: return {31'b0, fetch_err};
    endcase
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, m_ph == P_FETCH});
    check("imem_addr", imem_addr, m_pc);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, m_ph == P_OFFER});
    check("inst", inst, m_inst);
    check("inst_pc", inst_pc, m_inst_pc);
    check("fetch_err", {31'b0, fetch_err}, {31'b0, m_ph == P_FAULT});
`ifdef IFU_PERF_CNT_EN
    check("perf_lo", perf_fetch_cnt[31:0], m_cnt[31:0]);
    check("perf_hi", perf_fetch_cnt[63:32], m_cnt[63:32]);
`endif
    while (lits.size() > 0) begin
      lit_t l;
      l = lits.pop_front();
      check(l.name, dut_sig(l.sel), l.val);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_fetch(input logic [31:0] data, input logic err);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
  endtask

  task automatic do_exec(input logic redir, input logic [31:0] rpc);
    inst_ready = 1'b1;
    step();
    inst_ready  = 1'b0;
    commit      = 1'b1;
    redirect    = redir;
    redirect_pc = rpc;
    step();
    commit   = 1'b0;
    redirect = 1'b0;
  endtask

  bit          outst;
  int unsigned pend;
  int          fault_cyc;

  initial begin
    step();
    step();
    expect_lit("rst_req_valid", 0, 32'd1);
    expect_lit("rst_addr", 1, RST_PC);
    expect_lit("rst_inst_valid", 2, 32'd0);
    expect_lit("rst_inst", 3, NOP);
    expect_lit("rst_inst_pc", 4, RST_PC);
    expect_lit("rst_fetch_err", 5, 32'd0);
    step();
    rst_n = 1'b1;
    expect_lit("first_addr", 1, 32'h8000_0000);
    do_fetch(32'h0010_0093, 1'b0);
    expect_lit("hold_valid", 2, 32'd1);
    expect_lit("hold_inst", 3, 32'h0010_0093);
    expect_lit("hold_pc", 4, 32'h8000_0000);
    do_exec(1'b0, 32'h0);
    expect_lit("seq_addr", 1, 32'h8000_0004);
    do_fetch(32'h0000_0517, 1'b0);
    expect_lit("latency_valid", 2, 32'd1);
    expect_lit("seq_inst_pc", 4, 32'h8000_0004);
    do_exec(1'b1, 32'h8000_0103);
    expect_lit("redir_addr", 1, 32'h8000_0100);

    // Memory stalls for five cycles, accepts on the sixth.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_lit("stall_valid", 0, 32'd1);
      expect_lit("stall_addr", 1, 32'h8000_0100);
      step();
    end
    imem_req_ready = 1'b1;
    expect_lit("stall_last_valid", 0, 32'd1);
    step();
    imem_req_ready = 1'b0;
    expect_lit("single_handshake", 0, 32'd0);
    commit      = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1234;
    step();
    commit   = 1'b0;
    redirect = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0297;
    step();
    imem_rsp_valid = 1'b0;
    commit         = 1'b1;
    redirect       = 1'b1;
    step();
    commit   = 1'b0;
    redirect = 1'b0;
    expect_lit("hold_after_commit", 2, 32'd1);
    expect_lit("hold_pc_unchanged", 4, 32'h8000_0100);
    do_exec(1'b0, 32'h0);
    expect_lit("ignored_commit_addr", 1, 32'h8000_0104);

    do_fetch(32'h0000_0013, 1'b0);
    do_exec(1'b1, 32'hFFFF_FFFE);
    expect_lit("align_addr", 1, 32'hFFFF_FFFC);
    do_fetch(32'h0000_0033, 1'b0);
    do_exec(1'b0, 32'h0);
    expect_lit("wrap_addr", 1, 32'h0000_0000);

    // Access fault: fetching stops until reset.
    do_fetch(32'hDEAD_BEEF, 1'b1);
    expect_lit("err_flag", 5, 32'd1);
    expect_lit("err_inst_pc", 4, 32'hFFFF_FFFC);
    for (int i = 0; i < 20; i++) begin
      imem_req_ready = 1'b1;
      commit         = i[0];
      expect_lit("err_no_req", 0, 32'd0);
      expect_lit("err_no_inst", 2, 32'd0);
      expect_lit("err_sticky", 5, 32'd1);
      step();
    end
    imem_req_ready = 1'b0;
    commit         = 1'b0;
    rst_n          = 1'b0;
    step();
    rst_n = 1'b1;
    expect_lit("recover_addr", 1, RST_PC);
    expect_lit("recover_req", 0, 32'd1);
    expect_lit("recover_err", 5, 32'd0);
    expect_lit("recover_inst", 3, NOP);
    step();

    // Randomized traffic with a small memory responder.
    outst     = 1'b0;
    pend      = 0;
    fault_cyc = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!rst_n) rst_n = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      if (outst) begin
        if (pend == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = $urandom;
          imem_rsp_err   = ($urandom_range(0, 63) == 0);
          outst          = 1'b0;
        end else begin
          pend--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
        imem_rsp_err   = 1'($urandom_range(0, 1));
      end
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if (imem_req_valid && imem_req_ready) begin
        outst = 1'b1;
        pend  = $urandom_range(0, 2);
      end
      inst_ready  = ($urandom_range(0, 2) != 0);
      commit      = ($urandom_range(0, 2) == 0);
      redirect    = 1'($urandom_range(0, 1));
      redirect_pc = $urandom;
      if (fetch_err) fault_cyc++;
      if (fault_cyc > 6 || $urandom_range(0, 499) == 0) begin
        rst_n          = 1'b0;
        outst          = 1'b0;
        imem_rsp_valid = 1'b0;
        fault_cyc      = 0;
      end
      step();
    end
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    commit         = 1'b0;
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
